// File: rtl/cond_pkg.sv
// cond_pkg: flag bit positions, branch opcodes and FSM states shared by the conditional-logic stage.
package cond_pkg;
   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;
   localparam logic [2:0] OP_EQ_B = 3'b111;
   localparam logic [2:0] OP_NE   = 3'b100;
   localparam logic [2:0] OP_GT   = 3'b101;
   localparam logic [2:0] OP_LT   = 3'b110;
   typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;
endpackage

// File: rtl/flag_scoreboard.sv
// flag_scoreboard: saturating count of in-flight flag writers, with readiness and protocol-error detection.
module flag_scoreboard #(
   parameter int MAX_PENDING = 3,
   parameter bit FWD_EN      = 1'b1,
   localparam int CW         = $clog2(MAX_PENDING + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic issue,
   input  logic issue_block,
   input  logic retire,
   output logic full,
   output logic empty,
   output logic flags_ready,
   output logic overflow,
   output logic underflow
);
   logic [CW-1:0] pending;
   logic          accept, dec;
   assign full        = pending == CW'(MAX_PENDING);
   assign empty       = pending == '0;
   assign overflow    = issue & (issue_block | full);
   assign underflow   = retire & empty;
   assign accept      = issue & ~issue_block & ~full;
   assign dec         = retire & ~empty;
   // the last outstanding writer retiring this cycle counts as ready when it can be forwarded
   assign flags_ready = empty | (FWD_EN & (pending == CW'(1)) & retire & ~issue);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else if (accept != dec) pending <= accept ? pending + 1'b1 : pending - 1'b1;
   end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: NZCV register, flag-writer scoreboard and branch-resolution handshake feeding condition_checker.
module flag_branch_unit
   import cond_pkg::*;
#(
   parameter int MAX_PENDING = 3,
   parameter bit FWD_EN      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_flag_set,
   input  logic       alu_flags_valid,
   input  logic [3:0] alu_flags,
   input  logic       br_req,
   input  logic [2:0] br_opcode,
   input  logic       br_V,
   input  logic       cond_ex,
   output logic [2:0] cc_opcode,
   output logic       cc_V,
   output logic       N_flag,
   output logic       Z_flag,
   output logic       C_flag,
   output logic       V_flag,
   output logic       br_ack,
   output logic       br_taken,
   output logic       stall_issue,
   output logic       proto_err
);
   state_t     state, state_n;
   logic [3:0] flags_q, flags_p;
   logic [2:0] op_q;
   logic       v_q, full, empty, flags_ready, overflow, underflow, br_accept;
   assign flags_p     = (FWD_EN && alu_flags_valid) ? alu_flags : flags_q;
   assign N_flag      = flags_p[N_BIT];
   assign Z_flag      = flags_p[Z_BIT];
   assign C_flag      = flags_p[C_BIT];
   assign V_flag      = flags_p[V_BIT];
   assign cc_opcode   = op_q;
   assign cc_V        = v_q;
   // a waiting branch blocks younger flag-setters so its flags cannot be overtaken
   assign stall_issue = full | br_req | (state != IDLE);
   // br_req still high during br_ack is the tail of the previous request
   assign br_accept   = (state == IDLE) & br_req & ~br_ack;
   flag_scoreboard #(.MAX_PENDING(MAX_PENDING), .FWD_EN(FWD_EN)) u_sb (
      .clk(clk), .rst(rst), .issue(issue_flag_set), .issue_block(stall_issue),
      .retire(alu_flags_valid), .full(full), .empty(empty), .flags_ready(flags_ready),
      .overflow(overflow), .underflow(underflow)
   );
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = br_accept ? ((br_V | flags_ready) ? EVAL : WAIT) : IDLE;
         WAIT:    state_n = flags_ready ? EVAL : WAIT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         flags_q   <= 4'b0000;
         op_q      <= 3'b000;
         v_q       <= 1'b0;
         br_ack    <= 1'b0;
         br_taken  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state  <= state_n;
         br_ack <= state == EVAL;
         if (alu_flags_valid) flags_q <= alu_flags;
         if (br_accept) {op_q, v_q} <= {br_opcode, br_V};
         if (state == EVAL) br_taken <= cond_ex;
         if (overflow | underflow) proto_err <= 1'b1;
      end
   end
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sequential stage directly upstream of condition_checker in the control unit's conditional logic.
- Holds the architectural NZCV flag register and scoreboards in-flight flag-setting instructions.
- Runs the branch-resolution FSM: drives opcode, V and flags to condition_checker, samples its condEx, and returns a registered taken/not-taken handshake to fetch/decode.
- Forwards ALU flags that arrive in the same cycle, so a branch never reads stale flags.

Parameters:
- MAX_PENDING, 3, maximum in-flight flag-setting instructions; counter width = $clog2(MAX_PENDING+1).
- FWD_EN, 1, 1 = bypass alu_flags to the checker in their writeback cycle; 0 = register-only path.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_flag_set  in  1  decode issued an instruction that will write flags.
- alu_flags_valid  in  1  ALU writes flags this cycle.
- alu_flags  in  4  {N,Z,C,V} from the ALU.
- br_req  in  1  branch request, level, held until br_ack.
- br_opcode  in  3  branch condition opcode.
- br_V  in  1  1 = unconditional branch.
- cond_ex  in  1  condEx returned combinationally by condition_checker.
- cc_opcode  out  3  opcode presented to condition_checker.
- cc_V  out  1  V presented to condition_checker.
- N_flag, Z_flag, C_flag, V_flag  out  1 each  flags presented to condition_checker.
- br_ack  out  1  one-cycle resolution pulse.
- br_taken  out  1  resolution result; valid only with br_ack.
- stall_issue  out  1  decode must not issue.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async): flags_q=4'b0000, pending=0, state=IDLE, br_ack=0, br_taken=0, proto_err=0, latched opcode=3'b000, latched V=0.
- Flag register: flags_q<=alu_flags on alu_flags_valid.
- Presented flags: alu_flags when FWD_EN && alu_flags_valid, else flags_q.
- Pending counter:
  - +1 on accepted issue_flag_set, -1 on alu_flags_valid; both in the same cycle = unchanged.
  - Decrement at 0: ignored, sets proto_err.
  - issue_flag_set while stall_issue=1: ignored (not counted), sets proto_err.
- flags_ready = (pending==0) | (FWD_EN & pending==1 & alu_flags_valid & ~issue_flag_set).
- stall_issue = (pending==MAX_PENDING) | br_req | (state!=IDLE). This prevents younger flag-setters from entering while a branch waits.
- FSM states IDLE, WAIT, EVAL:
  - IDLE: when br_req & ~br_ack, latch br_opcode/br_V.
    - Go to EVAL if br_V | flags_ready, else WAIT.
  - WAIT: go to EVAL when flags_ready; otherwise stay.
  - EVAL (exactly 1 cycle): cc_opcode/cc_V = latched values; register br_taken<=cond_ex, br_ack<=1; go to IDLE.
  - cc_opcode/cc_V = latched values in every state; they are only meaningful in EVAL.
- br_ack is high exactly one cycle, the cycle after EVAL.
  - The requester drops br_req in the br_ack cycle.
  - br_req seen together with br_ack is not a new request.
- Latency: br_req at cycle t with flags ready → EVAL at t+1 → br_ack at t+2. Each WAIT cycle adds one.
- Unconditional branch (br_V=1) never waits on pending flags.
- rst asserted mid-WAIT/EVAL: immediate return to IDLE with no br_ack; the in-flight branch is dropped.

Decomposition:
- Package cond_pkg:
  - flag bit indices N=3, Z=2, C=1, V=0.
  - Opcode constants OP_EQ_B=3'b111, OP_NE=3'b100, OP_GT=3'b101, OP_LT=3'b110.
  - FSM state enum {IDLE, WAIT, EVAL}.
- Sub-module flag_scoreboard: the saturating pending counter, full/empty, flags_ready and underflow/overflow error outputs.
- The top level holds flags_q, forwarding mux, FSM and handshake.

Test Plan:
- Reset then alu_flags_valid=1, alu_flags=4'b0100; next cycle br_req, opcode 3'b111, V=0 → Z_flag=1 at EVAL, br_ack at t+2 with br_taken=1.
- issue_flag_set ×2; br_req opcode 3'b100 (NE) → stall_issue=1, FSM holds WAIT for 2 writebacks (flags 4'b0000 last) → br_taken=1 one cycle after EVAL.
- FWD_EN=1, pending=1, br_req (GT) in WAIT, alu_flags=4'b0000 valid → EVAL next cycle, no extra WAIT, br_taken=1. With FWD_EN=0 → one extra WAIT cycle.
- br_V=1, opcode 3'b111, pending=3 → EVAL immediately, br_taken=1, pending unchanged at 3.
- Protocol errors: alu_flags_valid with pending=0, and issue_flag_set while pending=MAX_PENDING → proto_err=1 sticky, counter unchanged (0 / 3).
- rst pulsed during WAIT → state IDLE, br_ack never asserts, flags_q=0, pending=0.
